// File: rtl/uart_pkg.sv
// Shared UART constants and the NCO phase-increment calculation.
package uart_pkg;

  function automatic longint unsigned calc_baud_inc(
    input longint unsigned freq,
    input longint unsigned baud,
    input longint unsigned os,
    input int unsigned     acc_width
  );
    return ((baud * os) << acc_width) / freq;
  endfunction

  localparam longint unsigned INC_9600_100M   = calc_baud_inc(64'd100000000, 64'd9600, 64'd16, 32);
  localparam longint unsigned INC_115200_100M = calc_baud_inc(64'd100000000, 64'd115200, 64'd16, 32);

endpackage

// File: rtl/uart_os_counter.sv
// Oversample counter: turns accumulator carries into mid-bit and end-of-bit strobes.
module uart_os_counter #(
  parameter int unsigned OVERSAMPLE = 16,
  localparam int unsigned CW = $clog2(OVERSAMPLE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          restart,
  input  logic          carry,
  output logic [CW-1:0] os_count,
  output logic          mid_tick,
  output logic          bit_tick
);
  import uart_pkg::*;

  localparam logic [CW-1:0] LAST    = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] MID_PRE = CW'(OVERSAMPLE / 2 - 1);

  logic [CW-1:0] count_q, count_d;
  logic          mid_q, mid_d;
  logic          bit_q, bit_d;
  logic          step;

  always_comb begin
    step    = enable && carry && !restart;
    count_d = count_q;
    mid_d   = 1'b0;
    bit_d   = 1'b0;
    if (restart) begin
      count_d = '0;
    end else if (step) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
      mid_d   = (count_q == MID_PRE);
      bit_d   = (count_q == LAST);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      mid_q   <= 1'b0;
      bit_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      mid_q   <= mid_d;
      bit_q   <= bit_d;
    end
  end

  assign os_count = count_q;
  assign mid_tick = mid_q;
  assign bit_tick = bit_q;

endmodule

// File: rtl/uart_baud_generator.sv
// NCO baud generator: phase accumulator, oversample/mid/bit strobes and a
// valid/ready increment register applied only at bit boundaries.
module uart_baud_generator #(
  parameter int unsigned FREQUENCY    = 100000000,
  parameter int unsigned DEFAULT_BAUD = 9600,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned ACC_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 restart,
  input  logic [ACC_WIDTH-1:0] cfg_inc,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic                 os_tick,
  output logic                 mid_tick,
  output logic                 bit_tick,
  output logic [ACC_WIDTH-1:0] cur_inc
);
  import uart_pkg::*;

  localparam int unsigned     CW            = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]   LAST          = CW'(OVERSAMPLE - 1);
  localparam longint unsigned DEFAULT_INC64 =
    calc_baud_inc(64'(FREQUENCY), 64'(DEFAULT_BAUD), 64'(OVERSAMPLE), ACC_WIDTH);
  localparam logic [ACC_WIDTH-1:0] DEFAULT_INC = ACC_WIDTH'(DEFAULT_INC64);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] cur_inc_q, cur_inc_d;
  logic [ACC_WIDTH-1:0] pend_inc_q, pend_inc_d;
  logic                 pending_q, pending_d;
  logic                 os_tick_q, os_tick_d;
  logic [ACC_WIDTH:0]   sum;
  logic                 carry, boundary, apply, take;
  logic [CW-1:0]        os_count;

  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, cur_inc_q};
    carry    = enable && !restart && sum[ACC_WIDTH];
    boundary = carry && (os_count == LAST);
    acc_d    = acc_q;
    if (restart)     acc_d = '0;
    else if (enable) acc_d = sum[ACC_WIDTH-1:0];
    os_tick_d = carry;
  end

  // Apply and capture are exclusive (capture needs pending_q=0), so a config
  // taken together with restart survives until the next restart/boundary.
  always_comb begin
    apply      = pending_q && (restart || !enable || boundary);
    take       = cfg_valid && !pending_q;
    cur_inc_d  = cur_inc_q;
    pend_inc_d = pend_inc_q;
    pending_d  = pending_q;
    if (apply) begin
      cur_inc_d = pend_inc_q;
      pending_d = 1'b0;
    end
    if (take) begin
      pend_inc_d = cfg_inc;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q      <= '0;
      cur_inc_q  <= DEFAULT_INC;
      pend_inc_q <= '0;
      pending_q  <= 1'b0;
      os_tick_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cur_inc_q  <= cur_inc_d;
      pend_inc_q <= pend_inc_d;
      pending_q  <= pending_d;
      os_tick_q  <= os_tick_d;
    end
  end

  uart_os_counter #(.OVERSAMPLE(OVERSAMPLE)) u_os_counter (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .restart  (restart),
    .carry    (carry),
    .os_count (os_count),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick)
  );

  assign os_tick   = os_tick_q;
  assign cur_inc   = cur_inc_q;
  assign cfg_ready = !pending_q;

endmodule

// File: tb/tb_uart_baud_generator.sv
// Bench for uart_baud_generator: small 8-bit/OS=4 instance against a carry-count
// model, plus a default-parameter instance against a closed-form tick schedule.
module tb_uart_baud_generator;

  localparam int unsigned     OS    = 4;
  localparam longint unsigned D_INC = 64'd6597069;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable, restart, cfg_valid;
  logic [7:0] cfg_inc;
  logic       s_cfg_ready, s_os_tick, s_mid_tick, s_bit_tick;
  logic [7:0] s_cur_inc;

  logic        d_enable, d_restart, d_cfg_valid;
  logic [31:0] d_cfg_inc;
  logic        d_cfg_ready, d_os_tick, d_mid_tick, d_bit_tick;
  logic [31:0] d_cur_inc;

  uart_baud_generator #(.FREQUENCY(8000), .DEFAULT_BAUD(1000), .OVERSAMPLE(4), .ACC_WIDTH(8)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .restart(restart),
    .cfg_inc(cfg_inc), .cfg_valid(cfg_valid), .cfg_ready(s_cfg_ready),
    .os_tick(s_os_tick), .mid_tick(s_mid_tick), .bit_tick(s_bit_tick), .cur_inc(s_cur_inc)
  );

  uart_baud_generator dut_d (
    .clk(clk), .reset(reset), .enable(d_enable), .restart(d_restart),
    .cfg_inc(d_cfg_inc), .cfg_valid(d_cfg_valid), .cfg_ready(d_cfg_ready),
    .os_tick(d_os_tick), .mid_tick(d_mid_tick), .bit_tick(d_bit_tick), .cur_inc(d_cur_inc)
  );

  initial forever #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Small-instance model: phase as an integer fraction of 256, ticks from the carry count.
  int unsigned m_phase, m_inc, m_pend_inc, m_carries;
  bit          m_pend, m_os, m_mid, m_bit;

  bit              d_chk = 1'b0;
  longint unsigned d_n = 0;
  int unsigned     d_bits = 0;
  longint unsigned d_third = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_inc = 128; m_pend_inc = 0; m_carries = 0;
    m_pend = 1'b0; m_os = 1'b0; m_mid = 1'b0; m_bit = 1'b0;
  endtask

  task automatic model_update();
    bit          old_pend;
    int unsigned tot;
    old_pend = m_pend;
    m_os = 1'b0; m_mid = 1'b0; m_bit = 1'b0;
    if (restart) begin
      m_phase = 0;
      m_carries = 0;
    end else if (enable) begin
      tot = m_phase + m_inc;
      if (tot >= 256) begin
        m_carries++;
        m_os  = 1'b1;
        m_mid = (m_carries % OS == OS / 2);
        m_bit = (m_carries % OS == 0);
      end
      m_phase = tot % 256;
    end
    if (old_pend && (restart || !enable || m_bit)) begin
      m_inc  = m_pend_inc;
      m_pend = 1'b0;
    end
    if (cfg_valid && !old_pend) begin
      m_pend_inc = int'(cfg_inc);
      m_pend     = 1'b1;
    end
  endtask

  task automatic step();
    longint unsigned c_now, c_prev;
    @(posedge clk);
    model_update();
    if (d_chk) d_n++;
    @(negedge clk);
    check("os_tick",   s_os_tick,    m_os);
    check("mid_tick",  s_mid_tick,   m_mid);
    check("bit_tick",  s_bit_tick,   m_bit);
    check("cur_inc",   s_cur_inc,    m_inc);
    check("cfg_ready", s_cfg_ready,  !m_pend);
    if (d_chk) begin
      c_now  = (d_n * D_INC) >> 32;
      c_prev = ((d_n - 1) * D_INC) >> 32;
      check("d_os_tick",  d_os_tick,  c_now != c_prev);
      check("d_mid_tick", d_mid_tick, (c_now != c_prev) && (c_now % 16 == 8));
      check("d_bit_tick", d_bit_tick, (c_now != c_prev) && (c_now % 16 == 0));
      if (d_bit_tick) begin
        d_bits++;
        if (d_bits == 3) d_third = d_n;
      end
    end
  endtask

  task automatic send_cfg(input logic [7:0] v);
    cfg_inc = v; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  initial begin
    int unsigned cnt, gap, min_gap, ticks_seen;
    bit          found;
    reset = 1'b0; enable = 1'b0; restart = 1'b0; cfg_valid = 1'b0; cfg_inc = '0;
    d_enable = 1'b1; d_restart = 1'b0; d_cfg_valid = 1'b0; d_cfg_inc = '0;
    model_reset();

    #12;
    check("rst_os_tick",   s_os_tick,   0);
    check("rst_mid_tick",  s_mid_tick,  0);
    check("rst_bit_tick",  s_bit_tick,  0);
    check("rst_cur_inc",   s_cur_inc,   128);
    check("rst_cfg_ready", s_cfg_ready, 1);
    check("rst_d_cur_inc", d_cur_inc,   6597069);

    @(negedge clk);
    reset = 1'b1; enable = 1'b1; d_chk = 1'b1;

    for (int n = 1; n <= 16; n++) begin
      step();
      check("pin_os",  s_os_tick,  (n % 2) == 0);
      check("pin_mid", s_mid_tick, (n == 4) || (n == 12));
      check("pin_bit", s_bit_tick, (n == 8) || (n == 16));
    end

    send_cfg(8'd96);
    check("frac_busy", s_cfg_ready, 0);
    pulse_restart();
    check("frac_inc", s_cur_inc, 96);
    cnt = 0;
    repeat (800) begin
      step();
      if (s_os_tick) cnt++;
    end
    check("frac_ticks_800", cnt, 300);

    send_cfg(8'd128);
    pulse_restart();
    repeat (3) step();
    send_cfg(8'd64);
    check("rcfg_busy", s_cfg_ready, 0);
    found = 1'b0; gap = 0; min_gap = 100;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      gap++;
      if (s_os_tick) begin
        if (gap < min_gap) min_gap = gap;
        gap = 0;
      end
      if (s_bit_tick) found = 1'b1;
    end
    check("rcfg_boundary_seen", found, 1);
    check("rcfg_new_inc", s_cur_inc, 64);
    check("rcfg_ready_again", s_cfg_ready, 1);
    check("rcfg_min_gap_ge2", min_gap >= 2, 1);
    for (int k = 0; k < 2; k++) begin
      cnt = 0; found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
        step();
        cnt++;
        if (s_os_tick) found = 1'b1;
      end
      check("rcfg_gap_after", cnt, 4);
    end

    send_cfg(8'd128);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (s_cfg_ready) found = 1'b1;
    end
    check("ralign_cfg_applied", s_cur_inc, 128);
    pulse_restart();
    repeat (6) step();
    pulse_restart();
    check("ralign_ticks_off", {s_os_tick, s_mid_tick, s_bit_tick}, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("ralign_os",  s_os_tick,  (k % 2) == 0);
      check("ralign_mid", s_mid_tick, k == 4);
      check("ralign_bit", s_bit_tick, k == 8);
    end

    pulse_restart();
    repeat (3) step();
    enable = 1'b0;
    ticks_seen = 0;
    repeat (10) begin
      step();
      if (s_os_tick || s_mid_tick || s_bit_tick) ticks_seen++;
    end
    check("hold_no_ticks", ticks_seen, 0);
    enable = 1'b1;
    step();
    check("hold_resume_os",  s_os_tick,  1);
    check("hold_resume_mid", s_mid_tick, 1);

    repeat (1500) begin
      enable    = ($urandom_range(0, 9) != 0);
      restart   = ($urandom_range(0, 29) == 0);
      cfg_valid = ($urandom_range(0, 14) == 0);
      case ($urandom_range(0, 5))
        0:       cfg_inc = 8'd0;
        1:       cfg_inc = 8'd128;
        2:       cfg_inc = 8'd96;
        3:       cfg_inc = 8'd64;
        default: cfg_inc = 8'($urandom_range(1, 255));
      endcase
      step();
    end
    enable = 1'b1; restart = 1'b0; cfg_valid = 1'b0;

    while (d_bits < 3 && d_n < 40000) step();
    check("d_three_bits_seen", d_bits >= 3, 1);
    check("d_third_bit_edge", d_third, (48 * (64'd1 << 32) + D_INC - 1) / D_INC);
    check("d_third_bit_window", (d_third >= 31247) && (d_third <= 31253), 1);

    send_cfg(8'd64);
    pulse_restart();
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (s_os_tick) found = 1'b1;
    end
    check("areset_tick_before", s_os_tick, 1);
    d_chk = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("areset_os_tick",   s_os_tick,   0);
    check("areset_cur_inc",   s_cur_inc,   128);
    check("areset_cfg_ready", s_cfg_ready, 1);
    check("areset_d_cur_inc", d_cur_inc,   6597069);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
